// File: rtl/parking_lot_gate_controller.sv
// Parking lot entry gate: occupancy counter with sticky over/underflow flags
// and a three-state gate FSM (closed / waiting for car / holding after entry).
module parking_lot_gate_controller #(
  parameter int CAPACITY     = 15,
  parameter int CNT_W        = 4,
  parameter int GATE_HOLD    = 8,
  parameter int OPEN_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_car_enter,
  input  logic             i_car_exit,
  input  logic             i_entry_req,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_gate_open,
  output logic             o_ovf_err,
  output logic             o_unf_err
);

  // state    | meaning
  // S_CLOSED | gate down, waiting for an entry request while not full
  // S_OPEN   | gate up, wait timer running until a car enters or it expires
  // S_HOLD   | car entered, gate held up until the hold timer runs out
  typedef enum logic [1:0] {
    S_CLOSED = 2'd0,
    S_OPEN   = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam int WT_W = $clog2(OPEN_TIMEOUT + 1);
  localparam int HT_W = $clog2(GATE_HOLD + 1);
  localparam logic [WT_W-1:0]  WAIT_LOAD = WT_W'(OPEN_TIMEOUT - 1);
  localparam logic [HT_W-1:0]  HOLD_LOAD = HT_W'(GATE_HOLD - 1);
  localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WT_W-1:0]  r_wait_tmr;
  logic [WT_W-1:0]  w_wait_tmr_nxt;
  logic [HT_W-1:0]  r_hold_tmr;
  logic [HT_W-1:0]  w_hold_tmr_nxt;
  logic             r_gate_open;
  logic             w_gate_open_nxt;

  logic [CNT_W-1:0] r_count;
  logic             r_ovf_err;
  logic             r_unf_err;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CAP_VAL);
  assign w_empty = (r_count == '0);

  // FSM state and timer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_CLOSED;
      r_wait_tmr <= '0;
      r_hold_tmr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_tmr <= w_wait_tmr_nxt;
      r_hold_tmr <= w_hold_tmr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_tmr_nxt = r_wait_tmr;
    w_hold_tmr_nxt = r_hold_tmr;
    case (r_state)
      S_CLOSED: begin
        if (i_entry_req && !w_full) begin
          w_state_nxt    = S_OPEN;
          w_wait_tmr_nxt = WAIT_LOAD;
        end
      end
      S_OPEN: begin
        if (i_car_enter) begin
          w_state_nxt    = S_HOLD;
          w_hold_tmr_nxt = HOLD_LOAD;
        end else if (r_wait_tmr == '0) begin
          w_state_nxt = S_CLOSED;
        end else begin
          w_wait_tmr_nxt = r_wait_tmr - 1'b1;
        end
      end
      S_HOLD: begin
        if (i_car_enter) begin
          w_hold_tmr_nxt = HOLD_LOAD;
        end else if (r_hold_tmr == '0) begin
          w_state_nxt = S_CLOSED;
        end else begin
          w_hold_tmr_nxt = r_hold_tmr - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_CLOSED;
      end
    endcase
  end

  // Gate drive is registered from the next state so it tracks the state exactly
  always_comb begin
    w_gate_open_nxt = (w_state_nxt != S_CLOSED);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gate_open <= 1'b0;
    end else begin
      r_gate_open <= w_gate_open_nxt;
    end
  end

  // Occupancy counter; clear wins, simultaneous enter/exit is a no-op
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else if (i_clr) begin
      r_count   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else if (i_car_enter && !i_car_exit) begin
      if (w_full) begin
        r_ovf_err <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_car_exit && !i_car_enter) begin
      if (w_empty) begin
        r_unf_err <= 1'b1;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_gate_open = r_gate_open;
  assign o_ovf_err   = r_ovf_err;
  assign o_unf_err   = r_unf_err;

endmodule

// File: doc/parking_lot_gate_controller.md
PARKING_LOT_GATE_CONTROLLER -- requirements
Module: parking_lot_gate_controller

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 15, giving the maximum occupancy (1..2^CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the occupancy counter width.
REQ-003 The block SHALL have parameter GATE_HOLD, default 8, giving the cycles the gate stays open after an entry (>=1).
REQ-004 The block SHALL have parameter OPEN_TIMEOUT, default 64, giving the cycles the gate waits for a car before closing (>=1).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_car_enter, input, 1 bit: a one-cycle pulse from the occupancy detector meaning a car has completed entry.
REQ-008 The block SHALL have port i_car_exit, input, 1 bit: a one-cycle pulse from the occupancy detector meaning a car has completed exit.
REQ-009 The block SHALL have port i_entry_req, input, 1 bit: a level signal meaning a driver is requesting entry at the gate.
REQ-010 The block SHALL have port i_clr, input, 1 bit: a synchronous clear of the count and error flags.
REQ-011 The block SHALL have port o_count, output, CNT_W bits: the current occupancy.
REQ-012 The block SHALL have port o_full, output, 1 bit: high when o_count == CAPACITY.
REQ-013 The block SHALL have port o_empty, output, 1 bit: high when o_count == 0.
REQ-014 The block SHALL have port o_gate_open, output, 1 bit: the registered gate drive.
REQ-015 The block SHALL have port o_ovf_err, output, 1 bit: a sticky flag for an entry attempted while full.
REQ-016 The block SHALL have port o_unf_err, output, 1 bit: a sticky flag for an exit attempted while empty.

Function
REQ-017 The gate FSM SHALL have exactly three states: S_CLOSED, S_OPEN and S_HOLD.
REQ-018 In S_CLOSED, the FSM SHALL move to S_OPEN on the next edge if i_entry_req=1 and o_full=0; a request while full SHALL be ignored.
REQ-019 On entering S_OPEN, the wait timer SHALL load OPEN_TIMEOUT-1.
REQ-020 In S_OPEN, i_car_enter=1 SHALL move the FSM to S_HOLD and load the hold timer with GATE_HOLD-1.
REQ-021 In S_OPEN, when the wait timer reaches 0 without i_car_enter, the FSM SHALL return to S_CLOSED.
REQ-022 In S_HOLD, the hold timer SHALL decrement each cycle, and the FSM SHALL move to S_CLOSED in the cycle after the timer reads 0.
REQ-023 i_car_enter pulses received in S_HOLD SHALL reload the hold timer.
REQ-024 o_gate_open SHALL be 1 exactly while the state is S_OPEN or S_HOLD, registered with no combinational path from the inputs.
REQ-025 The count SHALL update one cycle after the triggering pulse.
REQ-026 The count SHALL apply, in this priority: i_clr sets it to 0; enter and exit together leave it unchanged; enter alone increments it; exit alone decrements it.
REQ-027 An enter alone at count == CAPACITY SHALL leave the count unchanged and set o_ovf_err.
REQ-028 An exit alone at count == 0 SHALL leave the count unchanged and set o_unf_err.
REQ-029 The count SHALL never wrap and never exceed CAPACITY.
REQ-030 A simultaneous enter and exit SHALL never set either error flag, even at the boundaries.
REQ-031 Car pulses arriving in S_CLOSED (tailgating) SHALL still update the count, with no FSM change.
REQ-032 o_ovf_err and o_unf_err SHALL remain set until i_clr or reset.
REQ-033 i_clr SHALL also clear both error flags, and i_clr SHALL NOT affect the FSM or its timers.
REQ-034 o_full and o_empty SHALL be decoded from the registered count.
REQ-035 If the count reaches full while in S_OPEN or S_HOLD, the FSM SHALL finish its current sequence normally.

Reset
REQ-036 While i_rst_n=0, the block SHALL immediately (asynchronously) force: count 0, o_empty 1, o_full 0, o_gate_open 0, both error flags 0, FSM S_CLOSED, both timers 0.
REQ-037 A reset mid-sequence in S_OPEN or S_HOLD SHALL drop o_gate_open immediately, with no partial count update.
REQ-038 The first state change after reset SHALL occur on the first rising edge after i_rst_n returns to 1.

Verification
REQ-039 The bench SHALL check entry: i_entry_req=1 at count 3 -> o_gate_open=1 next cycle; i_car_enter pulse -> count 4 next cycle; gate stays open 8 more cycles, then 0.
REQ-040 The bench SHALL check timeout: i_entry_req=1 with no car -> o_gate_open high for exactly 64 cycles, then closed, count unchanged.
REQ-041 The bench SHALL check full: count 15, i_entry_req=1 -> gate stays closed; i_car_enter -> count stays 15 and o_ovf_err=1; i_clr -> count 0, o_ovf_err=0, o_empty=1.
REQ-042 The bench SHALL check simultaneous events: at count 0, enter and exit in the same cycle -> count 0, o_unf_err=0; at count 15 the same stimulus -> count 15, o_ovf_err=0.
REQ-043 The bench SHALL check underflow: count 0, i_car_exit -> count 0, o_unf_err=1, and the flag persists 10 cycles later.
REQ-044 The bench SHALL check reset mid-operation: assert i_rst_n=0 in S_HOLD at count 7 -> o_gate_open=0 and count 0 before the next clock edge.
